// File: rtl/tag_match_encoder_if.sv
// Lookup bus between the L2 set-read stage and the tag match/encode stage.
// The master side presents one lookup per cycle; the slave side returns the registered result.
interface tag_match_encoder_if #(
    parameter int WAYS     = 8,
    parameter int TAG_BITS = 12
) ();
    localparam int WAY_BITS = $clog2(WAYS);

    logic                     req_valid;
    logic [TAG_BITS-1:0]      addr_tag;
    logic [WAYS*TAG_BITS-1:0] way_tags;
    logic [WAYS-1:0]          way_valid;

    logic                     hit;
    logic                     miss;
    logic [WAY_BITS-1:0]      hit_way;
    logic [WAYS-1:0]          match_vec;
    logic                     multi_hit;

    modport master (
        output req_valid, addr_tag, way_tags, way_valid,
        input  hit, miss, hit_way, match_vec, multi_hit
    );

    modport slave (
        input  req_valid, addr_tag, way_tags, way_valid,
        output hit, miss, hit_way, match_vec, multi_hit
    );
endinterface

// File: rtl/tag_match_encoder.sv
// L2 lookup tag match: per-way compare, lowest-index priority encode, one-cycle result register.
// Optional multi-hit detection is enabled by defining TAG_MATCH_MULTIHIT_EN.

// Single way comparator: a tag match only counts on a non-Invalid way.
module tag_match_cmp #(
    parameter int TAG_BITS = 12
) (
    input  logic                i_valid,
    input  logic [TAG_BITS-1:0] i_way_tag,
    input  logic [TAG_BITS-1:0] i_addr_tag,
    output logic                o_match
);
    assign o_match = i_valid & (i_way_tag == i_addr_tag);
endmodule

module tag_match_encoder #(
    parameter int WAYS     = 8,
    parameter int TAG_BITS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    tag_match_encoder_if.slave  bus
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic [WAYS-1:0][TAG_BITS-1:0] w_way_tags;
    logic [WAYS-1:0]               w_match;
    logic                          w_any;
    logic [WAY_BITS-1:0]           w_enc;

    logic                          r_hit;
    logic                          r_miss;
    logic [WAY_BITS-1:0]           r_hit_way;
    logic [WAYS-1:0]               r_match_vec;

    assign w_way_tags = bus.way_tags;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        tag_match_cmp #(.TAG_BITS(TAG_BITS)) u_cmp (
            .i_valid    (bus.way_valid[g]),
            .i_way_tag  (w_way_tags[g]),
            .i_addr_tag (bus.addr_tag),
            .o_match    (w_match[g])
        );
    end

    assign w_any = |w_match;

    // Scan high to low so the lowest set index is the last writer and wins.
    always_comb begin
        w_enc = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_match[i]) w_enc = WAY_BITS'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_hit_way   <= '0;
            r_match_vec <= '0;
        end else begin
            r_hit       <= bus.req_valid & w_any;
            r_miss      <= bus.req_valid & ~w_any;
            r_hit_way   <= (bus.req_valid & w_any) ? w_enc : '0;
            r_match_vec <= bus.req_valid ? w_match : '0;
        end
    end

`ifdef TAG_MATCH_MULTIHIT_EN
    logic w_multi;
    logic r_multi_hit;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi = |(w_match & (w_match - WAYS'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_multi_hit <= 1'b0;
        else        r_multi_hit <= bus.req_valid & w_multi;
    end

    assign bus.multi_hit = r_multi_hit;
`else
    assign bus.multi_hit = 1'b0;
`endif

    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;
    assign bus.hit_way   = r_hit_way;
    assign bus.match_vec = r_match_vec;
endmodule

// File: tb/tb_tag_match_encoder.sv
// Directed bench for tag_match_encoder: driver pushes hand-computed results, a negedge monitor pops and compares.
module tb_tag_match_encoder;
    localparam int WAYS = 8;
    localparam int TB   = 12;

`ifdef TAG_MATCH_MULTIHIT_EN
    localparam logic MH = 1'b1;
`else
    localparam logic MH = 1'b0;
`endif

    typedef struct {
        logic       hit;
        logic       miss;
        logic [2:0] way;
        logic [7:0] mv;
        logic       mh;
        int         due;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    tag_match_encoder_if #(.WAYS(WAYS), .TAG_BITS(TB)) bus ();

    tag_match_encoder #(.WAYS(WAYS), .TAG_BITS(TB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Way i holds 12'h100+i unless selected, in which case it holds t.
    function automatic logic [WAYS*TB-1:0] tags_with(input logic [7:0] sel, input logic [TB-1:0] t);
        logic [WAYS*TB-1:0] r;
        for (int i = 0; i < WAYS; i++) r[i*TB +: TB] = sel[i] ? t : TB'(12'h100 + i);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (bus.hit !== e.hit || bus.miss !== e.miss || bus.hit_way !== e.way ||
                bus.match_vec !== e.mv || bus.multi_hit !== e.mh) begin
                n_fail++;
                $display("FAIL %s: got hit=%b miss=%b way=%0d mv=%h mh=%b, want hit=%b miss=%b way=%0d mv=%h mh=%b",
                         e.name, bus.hit, bus.miss, bus.hit_way, bus.match_vec, bus.multi_hit,
                         e.hit, e.miss, e.way, e.mv, e.mh);
            end
        end
    end

    task automatic push(input string name, input logic h, input logic m, input logic [2:0] w,
                        input logic [7:0] mv, input logic mh);
        exp_t e;
        e.hit = h; e.miss = m; e.way = w; e.mv = mv; e.mh = mh; e.due = cyc + 1; e.name = name;
        q.push_back(e);
    endtask

    task automatic drive(input string name, input logic v, input logic [TB-1:0] tag,
                         input logic [WAYS*TB-1:0] tags, input logic [7:0] vld,
                         input logic h, input logic m, input logic [2:0] w,
                         input logic [7:0] mv, input logic mh);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.addr_tag  = tag;
        bus.way_tags  = tags;
        bus.way_valid = vld;
        push(name, h, m, w, mv, mh);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if (bus.hit !== 1'b0 || bus.miss !== 1'b0 || bus.hit_way !== 3'd0 ||
            bus.match_vec !== 8'h00 || bus.multi_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got hit=%b miss=%b way=%0d mv=%h mh=%b, want all zero",
                     name, bus.hit, bus.miss, bus.hit_way, bus.match_vec, bus.multi_hit);
        end
    endtask

    initial begin
        int waited;
        rst_n         = 1'b0;
        bus.req_valid = 1'b1;
        bus.addr_tag  = 12'hABC;
        bus.way_tags  = tags_with(8'h20, 12'hABC);
        bus.way_valid = 8'hFF;

        // Matching request held through reset must not leak out.
        repeat (2) @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk) check_zero("reset_hold_neg");

        // First capture is the first edge with rst_n high.
        @(posedge clk);
        #1 rst_n = 1'b1;
        push("first_capture", 1, 0, 3'd5, 8'h20, 0);

        drive("single_hit",   1, 12'hABC, tags_with(8'h20, 12'hABC), 8'hFF, 1, 0, 3'd5, 8'h20, 0);
        drive("invalid_match",1, 12'hABC, tags_with(8'h20, 12'hABC), 8'hDF, 0, 1, 3'd0, 8'h00, 0);
        drive("priority",     1, 12'h123, tags_with(8'h44, 12'h123), 8'hFF, 1, 0, 3'd2, 8'h44, MH);
        drive("b2b_hit7",     1, 12'hABC, tags_with(8'h80, 12'hABC), 8'hFF, 1, 0, 3'd7, 8'h80, 0);
        drive("b2b_miss",     1, 12'h555, tags_with(8'h00, 12'h000), 8'hFF, 0, 1, 3'd0, 8'h00, 0);
        drive("b2b_idle",     0, 12'hABC, tags_with(8'h80, 12'hABC), 8'hFF, 0, 0, 3'd0, 8'h00, 0);
        drive("all_invalid",  1, 12'hABC, tags_with(8'h20, 12'hABC), 8'h00, 0, 1, 3'd0, 8'h00, 0);
        drive("tag_ones",     1, 12'hFFF, tags_with(8'h01, 12'hFFF), 8'hFF, 1, 0, 3'd0, 8'h01, 0);
        drive("tag_zeros",    1, 12'h000, tags_with(8'h08, 12'h000), 8'hFF, 1, 0, 3'd3, 8'h08, 0);
        drive("lsb_diff",     1, 12'hABD, tags_with(8'h20, 12'hABC), 8'hFF, 0, 1, 3'd0, 8'h00, 0);
        drive("msb_diff",     1, 12'h2BC, tags_with(8'h20, 12'hABC), 8'hFF, 0, 1, 3'd0, 8'h00, 0);
        drive("all_match",    1, 12'h5A5, tags_with(8'hFF, 12'h5A5), 8'hFF, 1, 0, 3'd0, 8'hFF, MH);
        drive("partial_vld",  1, 12'h5A5, tags_with(8'hFF, 12'h5A5), 8'h30, 1, 0, 3'd4, 8'h30, MH);
        drive("idle_match",   0, 12'h5A5, tags_with(8'hFF, 12'h5A5), 8'hFF, 0, 0, 3'd0, 8'h00, 0);

        // Mid-cycle reset after a hit is captured and checked; the pending lookup is dropped.
        drive("pre_reset_hit",1, 12'hABC, tags_with(8'h20, 12'hABC), 8'hFF, 1, 0, 3'd5, 8'h20, 0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk);
        #1 check_zero("reset_discard");
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        push("post_reset_idle", 0, 0, 3'd0, 8'h00, 0);

        drive("post_reset_hit", 1, 12'hABC, tags_with(8'h20, 12'hABC), 8'hFF, 1, 0, 3'd5, 8'h20, 0);
        drive("final_idle",     0, 12'h000, tags_with(8'h00, 12'h000), 8'h00, 0, 0, 3'd0, 8'h00, 0);

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/tag_match_encoder.md
# tag_match_encoder

- Lookup-side tag match stage of the L2 cache.
- Compares one request tag against the stored tags of all ways in the indexed set, qualified by each way's valid state.
- Reduces the per-way match vector to a binary way number, with hit/miss flags registered one cycle later.
- Feeds way selection for the data/MESI multiplexor and the LRU update logic.

## Interface
- WAYS, 8, associativity; power of two, minimum 2.
- TAG_BITS, 12, width of address tag and stored tags.
- WAY_BITS, $clog2(WAYS), derived; width of encoded way number (not overridable).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  lookup request this cycle.
- addr_tag  input  TAG_BITS  tag field of request address.
- way_tags  input  WAYS*TAG_BITS  stored tags of indexed set; way i at bits [i*TAG_BITS +: TAG_BITS].
- way_valid  input  WAYS  1 = way holds a non-Invalid MESI state. The caller derives this from MESI; 4'b0001 is Invalid.
- hit  output  1  registered: request matched a valid way.
- miss  output  1  registered: request matched no valid way.
- hit_way  output  WAY_BITS  registered encoded matching way.
- match_vec  output  WAYS  registered per-way match vector.
- multi_hit  output  1  registered: more than one valid way matched.

## Operation
- Comparator stage:
  - One equality comparator per way.
  - match[i] = way_valid[i] & (way_tags[i] == addr_tag).
  - Purely combinational, full TAG_BITS compare.
- Encoder stage:
  - Priority encoder over match.
  - Lowest-index set bit wins.
  - Output is 0 when no bit is set.
- Result register:
  - Captures the following each cycle: hit = req_valid & |match, miss = req_valid & ~|match, match_vec = req_valid ? match : 0, hit_way = encoder output if hit else 0.
  - With no request, hit, miss, match_vec, hit_way and multi_hit are all 0.
  - hit and miss are mutually exclusive; exactly one is 1 in a cycle following a request.
- Inputs are sampled only at the capturing edge. No internal state beyond the result register.

## Timing
- Latency: exactly 1 cycle. A request present at edge N produces its result valid after edge N; it holds until edge N+1.
- Throughput: one lookup per cycle; back-to-back requests are allowed. No handshake and no stall.
- Reset: rst_n low immediately (asynchronously) forces hit=0, miss=0, hit_way=0, match_vec=0, multi_hit=0.
  - Outputs stay 0 while rst_n is low.
  - The first capture occurs at the first rising edge with rst_n high.
- Reset asserted mid-lookup discards the pending result; no result is produced for that request.
- Boundary cases:
  - Tag matches on an invalid way: ignored.
  - All ways invalid: miss.
  - addr_tag all-ones or all-zeros: no special treatment.

## Configuration
- Macro TAG_MATCH_MULTIHIT_EN.
- When defined:
  - multi_hit = req_valid & (popcount(match) > 1), registered with the other outputs.
  - hit and hit_way still follow lowest-index priority.
- When undefined:
  - multi_hit is tied to 0.
  - No population-count logic is synthesized.
  - All other behaviour is identical.

## Test plan
- Reset: drive rst_n=0 mid-cycle with req_valid=1 and a matching way.
  - All outputs go to 0 immediately and stay 0 until the first edge after release.
- Single hit: WAYS=8, addr_tag=12'hABC, way 5 tag 12'hABC, all way_valid=8'hFF, other tags distinct.
  - Next cycle: hit=1, miss=0, hit_way=5, match_vec=8'h20.
- Invalid match: the single-hit case with way_valid=8'hDF.
  - Next cycle: hit=0, miss=1, hit_way=0, match_vec=0.
- Priority / multi-hit: ways 2 and 6 both 12'h123, addr_tag=12'h123, all valid.
  - hit_way=2, match_vec=8'h44.
  - multi_hit=1 with TAG_MATCH_MULTIHIT_EN defined, 0 without.
- Back-to-back: hit on way 7, then a miss, then req_valid=0 on consecutive cycles.
  - Outputs sequence is (hit, way 7), (miss), (all 0), each one cycle after its request.
